// File: rtl/rowbias_shuffler.sv
`default_nettype none
// ============================================================================
//  Module   : rowbias_shuffler
//  Purpose  : Per-row bias bus source. Holds a pool of W one-hot values that
//             always form a permutation. After reset, or on reseed, it shuffles
//             the pool with an LFSR-driven Fisher-Yates pass. Rejection
//             sampling is bounded by MAX_TRIES. Once the shuffle is done it
//             serves indexed lookups onto a registered bus.
//  Ports    : clock     - single clock, rising edge
//             reset     - asynchronous, active-high
//             reseed    - pulse: restart the shuffle from seed_in
//             seed_in   - seed captured on reseed (0 selects SEED)
//             update    - load pool[lowest set bit of rqindex] into busvalue
//             rqindex   - lookup index, expected one-hot
//             busvalue  - registered bus value
//             ready     - pool is a completed permutation, lookups honoured
//  Revision : 1.0  initial release
// ============================================================================
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

module rowbias_shuffler #(
   parameter int                W         = `GRID_LEN,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
   parameter int                MAX_TRIES = 4,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              reseed,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              update,
   input  logic [W-1:0]      rqindex,
   output logic [W-1:0]      busvalue,
   output logic              ready
);

   localparam int K  = $clog2(W);
   localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   typedef enum logic [0:0] {
      SHUFFLE = 1'b0,
      IDLE    = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [LFSR_W-1:0] lfsr, lfsr_nx;
   logic [K-1:0]      step, step_nx;
   logic [TW-1:0]     tries, tries_nx;
   logic [K-1:0]      r;
   logic              do_swap;
   logic              step_done;
   logic [W-1:0]      pool [W];
   logic [W-1:0]      lookup;

   // ------------------------------------------------------------------------
   // Next-state logic. Reseed overrides everything, including a shuffle step.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx  = state;
      lfsr_nx   = lfsr;
      step_nx   = step;
      tries_nx  = tries;
      do_swap   = 1'b0;
      step_done = 1'b0;
      r         = lfsr[K-1:0];
      if (reseed) begin
         state_nx = SHUFFLE;
         lfsr_nx  = (seed_in == '0) ? SEED : seed_in;
         step_nx  = K'(W-1);
         tries_nx = '0;
      end else if (state == SHUFFLE) begin
         // Galois LFSR, shift right
         lfsr_nx = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
         if (r <= step) begin
            do_swap   = 1'b1;
            step_done = 1'b1;
         end else if (tries == TW'(MAX_TRIES-1)) begin
            // Out of attempts: leave pool[step] where it is. This is still a
            // valid permutation, only slightly less uniform.
            step_done = 1'b1;
         end else begin
            tries_nx = tries + TW'(1);
         end
         if (step_done) begin
            step_nx  = step - K'(1);
            tries_nx = '0;
            if (step == K'(1)) begin
               state_nx = IDLE;
            end
         end
      end
   end

   // Lowest set bit of rqindex wins; scanning high-to-low lets it overwrite.
   always_comb begin
      lookup = '0;
      for (int j = W-1; j >= 0; j--) begin
         if (rqindex[j]) begin
            lookup = pool[j];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= SHUFFLE;
         lfsr  <= SEED;
         step  <= K'(W-1);
         tries <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_nx;
         lfsr  <= lfsr_nx;
         step  <= step_nx;
         tries <= tries_nx;
         // Tracks the state register so ready rises on the same edge
         // that enters IDLE.
         ready <= (state_nx == IDLE);
      end
   end

   // ------------------------------------------------------------------------
   // Pool: identity on reset/reseed, single swap per completed step.
   // The swap is an exchange, so the pool stays a permutation mid-shuffle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < W; j++) begin
            pool[j] <= W'(1) << j;
         end
      end else if (reseed) begin
         for (int j = 0; j < W; j++) begin
            pool[j] <= W'(1) << j;
         end
      end else if (do_swap) begin
         pool[step] <= pool[r];
         pool[r]    <= pool[step];
      end
   end

   // ------------------------------------------------------------------------
   // Bus register: only IDLE lookups load it. A reseed in the same cycle
   // leaves it unchanged.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busvalue <= '0;
      end else if (update && !reseed && (state == IDLE)) begin
         busvalue <= lookup;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rowbias_shuffler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rowbias_shuffler
//  Purpose  : Self-checking bench for rowbias_shuffler with one W=4 and one
//             W=9 instance. A behavioural Fisher-Yates model predicts the
//             permutation and the ready latency for a given seed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rowbias_shuffler;

   logic        clock;
   logic        rst_a, reseed_a, upd_a, rdy_a;
   logic [15:0] seed_a;
   logic [3:0]  rq_a, bus_a;
   logic        rst_b, reseed_b, upd_b, rdy_b;
   logic [15:0] seed_b;
   logic [8:0]  rq_b, bus_b;

   int errors;
   int checks;

   logic [15:0] m_perm [16];
   int          m_lat;
   logic [3:0]  exp4 [4];
   int          lat4;
   logic [3:0]  obs_a [4];
   logic [8:0]  obs_b [9];
   logic [8:0]  first_b [9];

   rowbias_shuffler #(.W(4)) dut_a (
      .clock(clock), .reset(rst_a), .reseed(reseed_a), .seed_in(seed_a),
      .update(upd_a), .rqindex(rq_a), .busvalue(bus_a), .ready(rdy_a)
   );

   rowbias_shuffler #(.W(9)) dut_b (
      .clock(clock), .reset(rst_b), .reseed(reseed_b), .seed_in(seed_b),
      .update(upd_b), .rqindex(rq_b), .busvalue(bus_b), .ready(rdy_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_shuffle(input int w, input logic [15:0] seed);
      logic [15:0] l;
      logic [15:0] t;
      int i, tries, r, k;
      l = (seed == 16'h0) ? 16'hACE1 : seed;
      k = $clog2(w);
      for (int j = 0; j < 16; j++) m_perm[j] = (j < w) ? (16'h1 << j) : 16'h0;
      i = w - 1; tries = 0; m_lat = 0;
      while (i >= 1) begin
         r = int'(l) % (1 << k);
         l = lfsr_next(l);
         m_lat++;
         if (r <= i) begin
            t = m_perm[i]; m_perm[i] = m_perm[r]; m_perm[r] = t;
            i--; tries = 0;
         end else if (tries == 3) begin
            i--; tries = 0;
         end else begin
            tries++;
         end
      end
   endtask

   // ---------------- helpers (no checking) ----------------
   task automatic wait_ready_a(output int cnt);
      cnt = 0;
      while (rdy_a !== 1'b1 && cnt < 200) begin
         @(posedge clock); #1; cnt++;
      end
   endtask

   task automatic read_perm_a();
      for (int j = 0; j < 4; j++) begin
         @(negedge clock); upd_a = 1'b1; rq_a = 4'(1 << j);
         @(posedge clock); #1; obs_a[j] = bus_a;
      end
      @(negedge clock); upd_a = 1'b0; rq_a = '0;
   endtask

   task automatic read_perm_b();
      for (int j = 0; j < 9; j++) begin
         @(negedge clock); upd_b = 1'b1; rq_b = 9'(1 << j);
         @(posedge clock); #1; obs_b[j] = bus_b;
      end
      @(negedge clock); upd_b = 1'b0; rq_b = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++; if (bus_a !== 4'h0) begin errors++; $display("FAIL reset_bus_a got=%h exp=0", bus_a); end
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_ready_a got=%b exp=0", rdy_a); end
      checks++; if (bus_b !== 9'h0) begin errors++; $display("FAIL reset_bus_b got=%h exp=0", bus_b); end
      checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL reset_ready_b got=%b exp=0", rdy_b); end
   endtask

   task automatic test_basic();
      int cnt;
      logic [3:0] orv;
      model_shuffle(4, 16'hACE1);
      for (int j = 0; j < 4; j++) exp4[j] = m_perm[j][3:0];
      lat4 = m_lat;
      @(negedge clock); rst_a = 1'b0;
      wait_ready_a(cnt);
      checks++; if (cnt != lat4) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", cnt, lat4); end
      checks++; if (cnt < 3 || cnt > 12) begin errors++; $display("FAIL basic_latency_range got=%0d exp=3..12", cnt); end
      read_perm_a();
      orv = '0;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (obs_a[j] !== exp4[j]) begin errors++; $display("FAIL basic_perm[%0d] got=%h exp=%h", j, obs_a[j], exp4[j]); end
         checks++;
         if ($countones(obs_a[j]) != 1) begin errors++; $display("FAIL basic_onehot[%0d] got=%h exp=one-hot", j, obs_a[j]); end
         orv |= obs_a[j];
      end
      checks++; if (orv !== 4'hF) begin errors++; $display("FAIL basic_or got=%h exp=f", orv); end
   endtask

   task automatic test_determinism();
      int cnt;
      logic [15:0] seeds [2];
      seeds[0] = 16'hACE1; seeds[1] = 16'h0000;
      for (int s = 0; s < 2; s++) begin
         @(negedge clock); reseed_a = 1'b1; seed_a = seeds[s];
         @(posedge clock); #1;
         checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL det_ready_drop seed=%h got=%b exp=0", seeds[s], rdy_a); end
         @(negedge clock); reseed_a = 1'b0;
         wait_ready_a(cnt);
         checks++; if (cnt != lat4) begin errors++; $display("FAIL det_latency seed=%h got=%0d exp=%0d", seeds[s], cnt, lat4); end
         read_perm_a();
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs_a[j] !== exp4[j]) begin errors++; $display("FAIL det_perm seed=%h [%0d] got=%h exp=%h", seeds[s], j, obs_a[j], exp4[j]); end
         end
      end
   endtask

   task automatic test_lookup_edges();
      logic [3:0] rq;
      int low;
      @(negedge clock); upd_a = 1'b1; rq_a = 4'b0000;
      @(posedge clock); #1;
      checks++; if (bus_a !== 4'h0) begin errors++; $display("FAIL lookup_zero got=%h exp=0", bus_a); end
      @(negedge clock); rq_a = 4'b0110;
      @(posedge clock); #1;
      checks++; if (bus_a !== exp4[1]) begin errors++; $display("FAIL lookup_0110 got=%h exp=%h", bus_a, exp4[1]); end
      for (int n = 0; n < 5; n++) begin
         @(negedge clock); upd_a = 1'b0; rq_a = (n == 0) ? 4'bxxxx : 4'($urandom_range(0, 15));
         @(posedge clock); #1;
         checks++; if (bus_a !== exp4[1]) begin errors++; $display("FAIL lookup_hold cyc=%0d got=%h exp=%h", n, bus_a, exp4[1]); end
      end
      for (int n = 0; n < 8; n++) begin
         rq = 4'($urandom_range(1, 15));
         low = 0;
         while (low < 3 && !rq[low]) low++;
         @(negedge clock); upd_a = 1'b1; rq_a = rq;
         @(posedge clock); #1;
         checks++; if (bus_a !== exp4[low]) begin errors++; $display("FAIL lookup_rand rq=%b got=%h exp=%h", rq, bus_a, exp4[low]); end
      end
      @(negedge clock); upd_a = 1'b1; rq_a = 4'b0010;
      @(posedge clock); #1;
      @(negedge clock); upd_a = 1'b0; rq_a = '0;
   endtask

   task automatic test_update_blocked();
      int cnt;
      // bus currently holds exp4[1]
      @(negedge clock); reseed_a = 1'b1; seed_a = 16'hACE1; upd_a = 1'b1; rq_a = 4'b0001;
      @(posedge clock); #1;
      checks++; if (bus_a !== exp4[1]) begin errors++; $display("FAIL blk_reseed_bus got=%h exp=%h", bus_a, exp4[1]); end
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL blk_reseed_ready got=%b exp=0", rdy_a); end
      @(negedge clock); reseed_a = 1'b0;
      cnt = 0;
      while (cnt < 100) begin
         if (rdy_a === 1'b1) break;
         upd_a = 1'b1; rq_a = 4'($urandom_range(1, 15));
         @(posedge clock); #1; cnt++;
         checks++; if (bus_a !== exp4[1]) begin errors++; $display("FAIL blk_shuffle_bus cyc=%0d got=%h exp=%h", cnt, bus_a, exp4[1]); end
         @(negedge clock);
      end
      upd_a = 1'b0; rq_a = '0;
      checks++; if (cnt != lat4) begin errors++; $display("FAIL blk_latency got=%0d exp=%0d", cnt, lat4); end
      @(negedge clock); reseed_a = 1'b1; upd_a = 1'b1; rq_a = 4'b1000;
      @(posedge clock); #1;
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL blk_idle_ready got=%b exp=0", rdy_a); end
      checks++; if (bus_a !== exp4[1]) begin errors++; $display("FAIL blk_idle_bus got=%h exp=%h", bus_a, exp4[1]); end
      @(negedge clock); reseed_a = 1'b0; upd_a = 1'b0; rq_a = '0;
      wait_ready_a(cnt);
      checks++; if (cnt != lat4) begin errors++; $display("FAIL blk_relatency got=%0d exp=%0d", cnt, lat4); end
   endtask

   task automatic test_async_reset();
      int cnt;
      @(negedge clock); upd_a = 1'b1; rq_a = 4'b0001;
      @(posedge clock); #1;
      checks++; if (bus_a !== exp4[0]) begin errors++; $display("FAIL arst_preload got=%h exp=%h", bus_a, exp4[0]); end
      @(negedge clock); upd_a = 1'b0; rq_a = '0; reseed_a = 1'b1; seed_a = 16'h1234;
      @(negedge clock); reseed_a = 1'b0;
      @(posedge clock); #3; rst_a = 1'b1;
      #1;
      checks++; if (bus_a !== 4'h0) begin errors++; $display("FAIL arst_bus got=%h exp=0", bus_a); end
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", rdy_a); end
      @(negedge clock); rst_a = 1'b0;
      wait_ready_a(cnt);
      checks++; if (cnt != lat4) begin errors++; $display("FAIL arst_latency got=%0d exp=%0d", cnt, lat4); end
      read_perm_a();
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (obs_a[j] !== exp4[j]) begin errors++; $display("FAIL arst_perm[%0d] got=%h exp=%h", j, obs_a[j], exp4[j]); end
      end
   endtask

   task automatic run_b_with_invariant(input int lat, input string tag);
      int cnt;
      logic [8:0] orv;
      bit ok;
      cnt = 0;
      while (rdy_b !== 1'b1 && cnt < 200) begin
         @(posedge clock); #1; cnt++;
         ok = 1'b1; orv = '0;
         for (int j = 0; j < 9; j++) begin
            if ($countones(dut_b.pool[j]) != 1) ok = 1'b0;
            orv |= dut_b.pool[j];
         end
         if (orv !== 9'h1FF) ok = 1'b0;
         checks++; if (!ok) begin errors++; $display("FAIL %s_invariant cyc=%0d or=%h exp=1ff", tag, cnt, orv); end
      end
      checks++; if (cnt != lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", tag, cnt, lat); end
   endtask

   task automatic test_seeds_w9();
      model_shuffle(9, 16'hACE1);
      @(negedge clock); rst_b = 1'b0;
      run_b_with_invariant(m_lat, "w9_ace1");
      read_perm_b();
      for (int j = 0; j < 9; j++) begin
         first_b[j] = obs_b[j];
         checks++;
         if (obs_b[j] !== m_perm[j][8:0]) begin errors++; $display("FAIL w9_ace1_perm[%0d] got=%h exp=%h", j, obs_b[j], m_perm[j][8:0]); end
      end
      model_shuffle(9, 16'h1234);
      @(negedge clock); reseed_b = 1'b1; seed_b = 16'h1234;
      @(negedge clock); reseed_b = 1'b0;
      run_b_with_invariant(m_lat, "w9_1234");
      read_perm_b();
      begin
         bit differ;
         differ = 1'b0;
         for (int j = 0; j < 9; j++) begin
            checks++;
            if (obs_b[j] !== m_perm[j][8:0]) begin errors++; $display("FAIL w9_1234_perm[%0d] got=%h exp=%h", j, obs_b[j], m_perm[j][8:0]); end
            if (obs_b[j] !== first_b[j]) differ = 1'b1;
         end
         checks++; if (!differ) begin errors++; $display("FAIL w9_seed_differ got=identical exp=different"); end
      end
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_a = 1'b1; reseed_a = 1'b0; seed_a = '0; upd_a = 1'b0; rq_a = '0;
      rst_b = 1'b1; reseed_b = 1'b0; seed_b = '0; upd_b = 1'b0; rq_b = '0;
      #12;
      test_reset();
      test_basic();
      test_determinism();
      test_lookup_edges();
      test_update_blocked();
      test_async_reset();
      test_seeds_w9();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
